// File: rtl/ulpi_io_reg.sv
// ulpi_io_reg: registered ULPI pad stage between the PHY pins and the link layer.
// Synchronises dir/nxt/data through IN_STAGES flops, flags turnaround cycles,
// classifies RX CMD vs RX data bytes, registers the TX path, releases the bus
// combinationally on raw dir, and drives a counted PHY reset pulse.
// Optional feature: define ULPI_IO_ABORT_DETECT_EN to build the TX abort state
// machine (tx_abort pulse and forced idle of the transmit byte after an abort).
module ulpi_io_reg #(
  parameter int DATA_W     = 8,
  parameter int IN_STAGES  = 1,   // 1 or 2
  parameter int RST_CYCLES = 64   // >= 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad_dir_i,
  input  logic              pad_nxt_i,
  input  logic [DATA_W-1:0] pad_data_i,
  output logic [DATA_W-1:0] pad_data_o,
  output logic              pad_data_oe,
  output logic              pad_stp_o,
  output logic              pad_rst_o,
  input  logic              phy_rst_req,
  output logic              phy_rst_busy,
  output logic              rx_dir,
  output logic              rx_nxt,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_turn,
  output logic              rx_cmd_valid,
  output logic              rx_data_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_stp,
  output logic              tx_abort
);

  // Counter only needs to hold the value RST_CYCLES.
  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  logic [IN_STAGES-1:0] r_dir_pipe;
  logic [IN_STAGES-1:0] r_nxt_pipe;
  logic [DATA_W-1:0]    r_data_pipe [IN_STAGES];
  logic                 r_dir_s_d;
  logic [CNT_W-1:0]     r_rst_cnt;
  logic [DATA_W-1:0]    r_pad_data_o;
  logic                 r_pad_stp_o;

  logic                 w_dir_1;
  logic                 w_dir_s;
  logic                 w_nxt_s;
  logic [DATA_W-1:0]    w_data_s;
  logic                 w_busy;
  logic                 w_turn;
  logic                 w_forced_idle;
  logic                 w_tx_abort;

  assign w_dir_1  = r_dir_pipe[0];
  assign w_dir_s  = r_dir_pipe[IN_STAGES-1];
  assign w_nxt_s  = r_nxt_pipe[IN_STAGES-1];
  assign w_data_s = r_data_pipe[IN_STAGES-1];
  assign w_busy   = (r_rst_cnt != '0);
  assign w_turn   = w_dir_s ^ r_dir_s_d;

  // Input synchroniser: stage 0 samples the pads, later stages shift along.
  // NOTE: the data pipe is a small array but is still reset, so rx_data is
  // defined from the first cycle instead of carrying X into the link logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_pipe <= '0;
      r_nxt_pipe <= '0;
      for (int i = 0; i < IN_STAGES; i++) r_data_pipe[i] <= '0;
      r_dir_s_d  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's
      // old value, which is what makes this a shift register.
      r_dir_pipe[0]  <= pad_dir_i;
      r_nxt_pipe[0]  <= pad_nxt_i;
      r_data_pipe[0] <= pad_data_i;
      for (int i = 1; i < IN_STAGES; i++) begin
        r_dir_pipe[i]  <= r_dir_pipe[i-1];
        r_nxt_pipe[i]  <= r_nxt_pipe[i-1];
        r_data_pipe[i] <= r_data_pipe[i-1];
      end
      r_dir_s_d <= w_dir_s;
    end
  end

  // PHY reset down-counter: a request (re)loads it, otherwise it runs to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_cnt <= CNT_W'(RST_CYCLES);
    end else if (phy_rst_req) begin
      r_rst_cnt <= CNT_W'(RST_CYCLES);
    end else if (w_busy) begin
      r_rst_cnt <= r_rst_cnt - CNT_W'(1);
    end
  end

`ifdef ULPI_IO_ABORT_DETECT_EN
  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_ACTIVE  = 2'd1,
    TX_ABORTED = 2'd2
  } tx_state_t;

  tx_state_t r_tx_state;
  tx_state_t w_tx_next;
  logic      w_dir_rise;

  assign w_dir_rise    = w_dir_s & ~r_dir_s_d;
  assign w_forced_idle = (r_tx_state == TX_ABORTED);

  // TX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  // TX next state and abort pulse; an abort outranks a same-cycle stop.
  // NOTE: both outputs get a default first so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_tx_next  = r_tx_state;
    w_tx_abort = 1'b0;
    if (w_busy) begin
      w_tx_next = TX_IDLE;
    end else begin
      unique case (r_tx_state)
        TX_IDLE: begin
          if (tx_data != '0 && !w_dir_s) w_tx_next = TX_ACTIVE;
        end
        TX_ACTIVE: begin
          if (w_dir_rise) begin
            w_tx_next  = TX_ABORTED;
            w_tx_abort = 1'b1;
          end else if (tx_stp) begin
            w_tx_next = TX_IDLE;
          end
        end
        TX_ABORTED: begin
          if (!w_dir_s && tx_data == '0) w_tx_next = TX_IDLE;
        end
        default: w_tx_next = TX_IDLE;
      endcase
    end
  end
`else
  // Without abort detection the link is trusted to idle by itself.
  assign w_forced_idle = 1'b0;
  assign w_tx_abort    = 1'b0;
`endif

  // Registered transmit path; the byte is zeroed whenever the PHY owns the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pad_data_o <= '0;
      r_pad_stp_o  <= 1'b0;
    end else begin
      r_pad_data_o <= (w_dir_s | w_forced_idle) ? '0 : tx_data;
      r_pad_stp_o  <= tx_stp & ~w_dir_s;
    end
  end

  assign pad_data_o    = r_pad_data_o;
  assign pad_stp_o     = r_pad_stp_o;
  assign pad_rst_o     = w_busy;
  assign phy_rst_busy  = w_busy;
  assign tx_abort      = w_tx_abort;

  assign rx_dir        = w_dir_s;
  assign rx_nxt        = w_nxt_s;
  assign rx_data       = w_data_s;
  assign rx_turn       = w_turn;
  assign rx_cmd_valid  = w_dir_s & ~w_nxt_s & ~w_turn & ~w_busy;
  assign rx_data_valid = w_dir_s &  w_nxt_s & ~w_turn & ~w_busy;

  // Release is immediate on raw dir; re-drive waits until the synchronised
  // turnaround cycle (dir_s differing from dir_s_d) has also gone by, giving
  // IN_STAGES+1 cycles from dir falling to the link driving again.
  assign pad_data_oe = ~pad_dir_i & ~w_dir_1 & ~w_dir_s & ~r_dir_s_d & ~w_busy;

endmodule

// File: tb/tb_ulpi_io_reg.sv
// tb_ulpi_io_reg: self-checking bench for ulpi_io_reg (IN_STAGES=2, RST_CYCLES=4).
// A behavioural model built on a sample history of the pads predicts every
// output each cycle; table vectors and hand sequences add fixed expectations.
module tb_ulpi_io_reg;

  localparam int DW  = 8;
  localparam int IN  = 2;
  localparam int RST = 4;
`ifdef ULPI_IO_ABORT_DETECT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pad_dir_i = 1'b0, pad_nxt_i = 1'b0;
  logic [DW-1:0] pad_data_i = '0, tx_data = '0;
  logic          tx_stp = 1'b0, phy_rst_req = 1'b0;
  logic [DW-1:0] pad_data_o, rx_data;
  logic          pad_data_oe, pad_stp_o, pad_rst_o, phy_rst_busy;
  logic          rx_dir, rx_nxt, rx_turn, rx_cmd_valid, rx_data_valid, tx_abort;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ulpi_io_reg #(.DATA_W(DW), .IN_STAGES(IN), .RST_CYCLES(RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .pad_dir_i(pad_dir_i), .pad_nxt_i(pad_nxt_i), .pad_data_i(pad_data_i),
    .pad_data_o(pad_data_o), .pad_data_oe(pad_data_oe), .pad_stp_o(pad_stp_o),
    .pad_rst_o(pad_rst_o), .phy_rst_req(phy_rst_req), .phy_rst_busy(phy_rst_busy),
    .rx_dir(rx_dir), .rx_nxt(rx_nxt), .rx_data(rx_data), .rx_turn(rx_turn),
    .rx_cmd_valid(rx_cmd_valid), .rx_data_valid(rx_data_valid),
    .tx_data(tx_data), .tx_stp(tx_stp), .tx_abort(tx_abort)
  );

  // ---------------- reference model ----------------
  // h_*[k] is the pad value sampled k+1 edges ago (h_*[IN-1] is what rx_* shows).
  bit            h_dir  [0:IN];
  bit            h_nxt  [0:IN];
  logic [DW-1:0] h_data [0:IN];
  int            rst_left;
  bit            m_sending, m_aborted;
  logic [DW-1:0] m_pdo;
  bit            m_stp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= IN; k++) begin
      h_dir[k] = 1'b0; h_nxt[k] = 1'b0; h_data[k] = '0;
    end
    rst_left = RST; m_sending = 1'b0; m_aborted = 1'b0; m_pdo = '0; m_stp = 1'b0;
  endtask

  task automatic model_check();
    bit busy, dir_s, turn, quiet, valid_ok, abort;
    busy  = (rst_left != 0);
    dir_s = h_dir[IN-1];
    turn  = (h_dir[IN-1] != h_dir[IN]);
    // The link may drive only when dir is low now and in every remembered sample.
    quiet = !pad_dir_i && !busy;
    for (int k = 0; k <= IN; k++) if (h_dir[k]) quiet = 1'b0;
    valid_ok = dir_s && !turn && !busy;
    abort = ABORT_EN && m_sending && dir_s && !h_dir[IN] && !busy;
    check("pad_data_o",    pad_data_o,    m_pdo);
    check("pad_stp_o",     pad_stp_o,     m_stp);
    check("pad_data_oe",   pad_data_oe,   quiet);
    check("pad_rst_o",     pad_rst_o,     busy);
    check("phy_rst_busy",  phy_rst_busy,  busy);
    check("rx_dir",        rx_dir,        dir_s);
    check("rx_nxt",        rx_nxt,        h_nxt[IN-1]);
    check("rx_data",       rx_data,       h_data[IN-1]);
    check("rx_turn",       rx_turn,       turn);
    check("rx_cmd_valid",  rx_cmd_valid,  valid_ok && !h_nxt[IN-1]);
    check("rx_data_valid", rx_data_valid, valid_ok && h_nxt[IN-1]);
    check("tx_abort",      tx_abort,      abort);
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit busy, dir_s, rise;
    busy  = (rst_left != 0);
    dir_s = h_dir[IN-1];
    rise  = dir_s && !h_dir[IN];
    m_pdo = (dir_s || (ABORT_EN && m_aborted)) ? '0 : tx_data;
    m_stp = tx_stp && !dir_s;
    if (busy) begin
      m_sending = 1'b0; m_aborted = 1'b0;
    end else if (m_sending) begin
      if (rise) begin m_sending = 1'b0; m_aborted = 1'b1; end
      else if (tx_stp) m_sending = 1'b0;
    end else if (m_aborted) begin
      if (!dir_s && tx_data == '0) m_aborted = 1'b0;
    end else if (tx_data != '0 && !dir_s) begin
      m_sending = 1'b1;
    end
    if (phy_rst_req)       rst_left = RST;
    else if (rst_left > 0) rst_left = rst_left - 1;
    for (int k = IN; k > 0; k--) begin
      h_dir[k] = h_dir[k-1]; h_nxt[k] = h_nxt[k-1]; h_data[k] = h_data[k-1];
    end
    h_dir[0] = pad_dir_i; h_nxt[0] = pad_nxt_i; h_data[0] = pad_data_i;
  endtask

  // Apply one cycle of inputs (just after an edge) and check against the model.
  task automatic drive(input logic d, input logic n, input logic [DW-1:0] data,
                       input logic [DW-1:0] tx, input logic stp, input logic req);
    pad_dir_i = d; pad_nxt_i = n; pad_data_i = data;
    tx_data = tx; tx_stp = stp; phy_rst_req = req;
    #2;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pad_dir_i = 1'b0; pad_nxt_i = 1'b0; pad_data_i = '0;
    tx_data = '0; tx_stp = 1'b0; phy_rst_req = 1'b0;
    model_reset();
    #1;
    model_check();
    check("reset_pad_rst", pad_rst_o, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          dir, nxt;
    logic [DW-1:0] data, tx;
    logic          e_turn, e_cmd, e_dval;
    logic [DW-1:0] e_rxd;
    logic          e_oe, e_rst;
  } vec_t;

  function automatic vec_t v(logic d, logic n, logic [DW-1:0] data, logic [DW-1:0] tx,
                             logic t, logic c, logic dv, logic [DW-1:0] rxd,
                             logic oe, logic rs);
    vec_t r;
    r.dir = d; r.nxt = n; r.data = data; r.tx = tx;
    r.e_turn = t; r.e_cmd = c; r.e_dval = dv; r.e_rxd = rxd; r.e_oe = oe; r.e_rst = rs;
    return r;
  endfunction

  vec_t vecs [14];

  initial begin
    // Reset release: pad_rst_o for exactly 4 cycles, bus not driven meanwhile.
    vecs[0]  = v(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    vecs[1]  = v(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    vecs[2]  = v(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    vecs[3]  = v(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1);
    vecs[4]  = v(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 0);
    // Link transmitting, then dir rises: same-cycle release, RX CMD then data.
    vecs[5]  = v(0, 0, 8'h00, 8'h41, 0, 0, 0, 8'h00, 1, 0);
    vecs[6]  = v(1, 0, 8'h00, 8'h41, 0, 0, 0, 8'h00, 0, 0);
    vecs[7]  = v(1, 0, 8'h4A, 8'h41, 0, 0, 0, 8'h00, 0, 0);
    vecs[8]  = v(1, 1, 8'h5A, 8'h41, 1, 0, 0, 8'h00, 0, 0);
    vecs[9]  = v(1, 0, 8'h00, 8'h41, 0, 1, 0, 8'h4A, 0, 0);
    // dir falls: bus comes back IN_STAGES+1 = 3 cycles later.
    vecs[10] = v(0, 0, 8'h00, 8'h41, 0, 0, 1, 8'h5A, 0, 0);
    vecs[11] = v(0, 0, 8'h00, 8'h41, 0, 1, 0, 8'h00, 0, 0);
    vecs[12] = v(0, 0, 8'h00, 8'h41, 1, 0, 0, 8'h00, 0, 0);
    vecs[13] = v(0, 0, 8'h00, 8'h41, 0, 0, 0, 8'h00, 1, 0);

    #2;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].dir, vecs[i].nxt, vecs[i].data, vecs[i].tx, 1'b0, 1'b0);
      check($sformatf("vec%0d_turn", i), rx_turn,       vecs[i].e_turn);
      check($sformatf("vec%0d_cmd",  i), rx_cmd_valid,  vecs[i].e_cmd);
      check($sformatf("vec%0d_dval", i), rx_data_valid, vecs[i].e_dval);
      check($sformatf("vec%0d_rxd",  i), rx_data,       vecs[i].e_rxd);
      check($sformatf("vec%0d_oe",   i), pad_data_oe,   vecs[i].e_oe);
      check($sformatf("vec%0d_rst",  i), pad_rst_o,     vecs[i].e_rst);
      tick();
    end

    for (int i = 0; i < 3; i++) begin drive(0, 0, 8'h00, 8'h00, 0, 0); tick(); end

    // Abort: 0x41, 0x12, then the PHY takes the bus while 0x12 is still offered.
    for (int j = 0; j <= 12; j++) begin
      logic          d;
      logic [DW-1:0] tx;
      d  = (j >= 2 && j <= 5);
      tx = (j == 0) ? 8'h41 : (j <= 9) ? 8'h12 : (j == 11) ? 8'h33 : 8'h00;
      drive(d, 1'b0, 8'h00, tx, 1'b0, 1'b0);
      if (j == 3 || j == 5) check($sformatf("abort_quiet%0d", j), tx_abort, 1'b0);
      if (j == 4)           check("abort_pulse", tx_abort, ABORT_EN);
      if (j >= 5 && j <= 8) check($sformatf("abort_idle%0d", j), pad_data_o, 8'h00);
      if (j == 10)          check("abort_hold", pad_data_o, ABORT_EN ? 8'h00 : 8'h12);
      if (j == 12)          check("abort_resume", pad_data_o, 8'h33);
      tick();
    end

    // Normal transmit ending in stp.
    for (int k = 0; k <= 4; k++) begin
      logic [DW-1:0] tx;
      tx = (k == 0) ? 8'h41 : (k == 1) ? 8'hAA : 8'h00;
      drive(1'b0, 1'b0, 8'h00, tx, k == 2, 1'b0);
      check($sformatf("tx%0d_abort", k), tx_abort, 1'b0);
      if (k == 1) check("tx_byte0", pad_data_o, 8'h41);
      if (k == 2) check("tx_byte1", pad_data_o, 8'hAA);
      if (k == 3) check("tx_stp_data", pad_data_o, 8'h00);
      if (k == 3) check("tx_stp", pad_stp_o, 1'b1);
      if (k == 4) check("tx_stp_end", pad_stp_o, 1'b0);
      tick();
    end

    // Reset request at R0 and again at R2 (steps 3 and 5): 6-cycle pulse, RX gated.
    for (int s = 0; s <= 10; s++) begin
      drive(1'b1, s[0], 8'(8'hC0 + s), 8'h00, 1'b0, s == 3 || s == 5);
      if (s >= 3) check($sformatf("rstx%0d_rst", s), pad_rst_o, s >= 4 && s <= 9);
      if (s >= 4 && s <= 9) begin
        check($sformatf("rstx%0d_cmd", s),  rx_cmd_valid,  1'b0);
        check($sformatf("rstx%0d_dval", s), rx_data_valid, 1'b0);
      end
      if (s == 10) check("rstx_rx_back", rx_cmd_valid | rx_data_valid, 1'b1);
      tick();
    end

    // Asynchronous reset in the middle of traffic.
    drive(1'b0, 1'b0, 8'h00, 8'h5C, 1'b0, 1'b0);
    tick();
    do_reset();

    // Randomised traffic against the model.
    begin
      logic d_cur;
      d_cur = 1'b0;
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(7) == 0) d_cur = ~d_cur;
        drive(d_cur, 1'($urandom_range(1)), 8'($urandom),
              ($urandom_range(1) != 0) ? 8'($urandom) : 8'h00,
              $urandom_range(7) == 0, $urandom_range(63) == 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
